// File: rtl/reset_release_sequencer_if.sv
// Reset request / downstream reset bundle between an upstream reset generator (master)
// and the reset release sequencer (slave).
interface reset_release_sequencer_if #(
    parameter int unsigned NUM_RST = 4
);
    logic               rst_req_n;
    logic [NUM_RST-1:0] rst_n_out;
    logic               done;
    logic               glitch_err;
    logic [7:0]         rel_cnt;

    modport master (
        output rst_req_n,
        input  rst_n_out,
        input  done,
        input  glitch_err,
        input  rel_cnt
    );

    modport slave (
        input  rst_req_n,
        output rst_n_out,
        output done,
        output glitch_err,
        output rel_cnt
    );
endinterface

// File: rtl/reset_release_sequencer.sv
// Synchronizes an upstream reset request, holds all downstream resets low for a minimum
// time, then releases them in index order with a fixed stagger between releases.
module reset_release_sequencer #(
    parameter int unsigned NUM_RST    = 4,
    parameter int unsigned STAGGER    = 8,
    parameter int unsigned MIN_ASSERT = 4
) (
    input logic                      clk,
    input logic                      rst_async,
    reset_release_sequencer_if.slave bus
);
    localparam logic [7:0]         MinAssert = 8'(MIN_ASSERT);
    localparam logic [7:0]         GlitchLim = 8'(MIN_ASSERT - 1);
    localparam logic [7:0]         StgLast   = 8'(STAGGER - 1);
    localparam logic [NUM_RST-1:0] FirstRel  = {{(NUM_RST - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StAssert, StSeq, StRun} state_e;

    state_e             state_q, state_d;
    logic               sync1_q, sync_q;
    logic [NUM_RST-1:0] rst_n_q, rst_n_d;
    logic               done_q, done_d;
    logic               glitch_q, glitch_d;
    logic               from_run_q, from_run_d;
    logic [7:0]         rel_cnt_q, rel_cnt_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         stg_q, stg_d;
    logic               last_rel;

    // Released bits always form a thermometer, so the final release is due once the
    // second-highest bit is already out.
    assign last_rel = rst_n_q[NUM_RST-2];

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync1_q <= bus.rst_req_n;
            sync_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            state_q    <= StAssert;
            rst_n_q    <= '0;
            done_q     <= 1'b0;
            glitch_q   <= 1'b0;
            from_run_q <= 1'b0;
            rel_cnt_q  <= '0;
            cnt_q      <= '0;
            stg_q      <= '0;
        end else begin
            state_q    <= state_d;
            rst_n_q    <= rst_n_d;
            done_q     <= done_d;
            glitch_q   <= glitch_d;
            from_run_q <= from_run_d;
            rel_cnt_q  <= rel_cnt_d;
            cnt_q      <= cnt_d;
            stg_q      <= stg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAssert: if (sync_q && cnt_q == MinAssert) state_d = StSeq;
            StSeq: begin
                if (!sync_q) begin
                    state_d = StAssert;
                end else if (stg_q == StgLast && last_rel) begin
                    state_d = StRun;
                end
            end
            StRun:    if (!sync_q) state_d = StAssert;
            default:  state_d = StAssert;
        endcase
    end

    always_comb begin
        rst_n_d    = rst_n_q;
        done_d     = done_q;
        glitch_d   = glitch_q;
        from_run_d = from_run_q;
        rel_cnt_d  = rel_cnt_q;
        cnt_d      = cnt_q;
        stg_d      = stg_q;
        unique case (state_q)
            StAssert: begin
                rst_n_d = '0;
                done_d  = 1'b0;
                if (cnt_q != MinAssert) cnt_d = cnt_q + 8'd1;
                // A request that returns before the hold time was nearly served is a glitch.
                if (from_run_q && sync_q && cnt_q < GlitchLim) glitch_d = 1'b1;
                if (sync_q && cnt_q == MinAssert) begin
                    rst_n_d = FirstRel;
                    stg_d   = '0;
                end
            end
            StSeq: begin
                if (!sync_q) begin
                    rst_n_d    = '0;
                    done_d     = 1'b0;
                    cnt_d      = '0;
                    from_run_d = 1'b1;
                end else if (stg_q == StgLast) begin
                    stg_d   = '0;
                    rst_n_d = {rst_n_q[NUM_RST-2:0], 1'b1};
                    if (last_rel) begin
                        done_d     = 1'b1;
                        from_run_d = 1'b1;
                        if (rel_cnt_q != 8'hff) rel_cnt_d = rel_cnt_q + 8'd1;
                    end
                end else begin
                    stg_d = stg_q + 8'd1;
                end
            end
            StRun: begin
                if (!sync_q) begin
                    rst_n_d    = '0;
                    done_d     = 1'b0;
                    cnt_d      = '0;
                    from_run_d = 1'b1;
                end
            end
            default: begin
                rst_n_d = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign bus.rst_n_out  = rst_n_q;
    assign bus.done       = done_q;
    assign bus.glitch_err = glitch_q;
    assign bus.rel_cnt    = rel_cnt_q;
endmodule

// File: tb/tb_reset_release_sequencer.sv
// Scoreboard bench: an edge-timestamp model predicts every output change; a negedge
// monitor pops and compares whenever the DUT outputs change or a change is due.
module tb_reset_release_sequencer;
    localparam int NUM_RST    = 4;
    localparam int STAGGER    = 8;
    localparam int MIN_ASSERT = 4;

    typedef struct packed {
        int                 edge_no;
        logic [NUM_RST-1:0] rst;
        logic               done;
        logic               glitch;
        logic [7:0]         rel;
    } exp_t;

    logic clk = 1'b0;
    logic rst_async;
    int   total = 0;
    int   bad = 0;
    int   edge_no = 0;

    reset_release_sequencer_if #(.NUM_RST(NUM_RST)) bus_if ();

    reset_release_sequencer #(
        .NUM_RST   (NUM_RST),
        .STAGGER   (STAGGER),
        .MIN_ASSERT(MIN_ASSERT)
    ) dut (
        .clk      (clk),
        .rst_async(rst_async),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model: start edge of the current hold, start edge of the current release
    // (-1 while holding), and the sticky/accumulated status.
    exp_t exp_q[$];
    exp_t last_exp = '0;
    bit   hist[$];
    int   assert_edge = 0;
    int   rel_edge = -1;
    bit   from_run = 1'b0;
    bit   m_glitch = 1'b0;
    int   m_rel = 0;

    function automatic logic [NUM_RST+9:0] vals(input exp_t x);
        return {x.rst, x.done, x.glitch, x.rel};
    endfunction

    function automatic exp_t model_out(input int e);
        exp_t x;
        x.edge_no = e;
        x.rst     = '0;
        x.done    = 1'b0;
        if (rel_edge >= 0) begin
            for (int k = 0; k < NUM_RST; k++) x.rst[k] = (e >= rel_edge + k * STAGGER);
            x.done = (e >= rel_edge + (NUM_RST - 1) * STAGGER);
        end
        x.glitch = m_glitch;
        x.rel    = 8'(m_rel);
        return x;
    endfunction

    task automatic push_if_changed(input exp_t x);
        if (vals(x) != vals(last_exp)) begin
            exp_q.push_back(x);
            last_exp = x;
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
        assert_edge = edge_no;
        rel_edge    = -1;
        from_run    = 1'b0;
        m_glitch    = 1'b0;
        m_rel       = 0;
        push_if_changed(model_out(edge_no));
    endtask

    task automatic model_edge();
        bit s;
        edge_no++;
        s = hist.pop_front();
        hist.push_back(bus_if.rst_req_n);
        if (rel_edge < 0) begin
            if (from_run && s && (edge_no - assert_edge - 1) < MIN_ASSERT - 1) m_glitch = 1'b1;
            if (s && edge_no - assert_edge >= MIN_ASSERT + 1) rel_edge = edge_no;
        end else if (!s) begin
            assert_edge = edge_no;
            rel_edge    = -1;
            from_run    = 1'b1;
        end else if (edge_no == rel_edge + (NUM_RST - 1) * STAGGER) begin
            if (m_rel < 255) m_rel++;
            from_run = 1'b1;
        end
        push_if_changed(model_out(edge_no));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic hold(input logic v, input int n);
        bus_if.rst_req_n = v;
        repeat (n) step();
    endtask

    task automatic chk(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // Monitor
    exp_t last_act = '0;
    int   ms = 0;
    int   low_start = 0;
    int   rise_ms[NUM_RST];

    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        bit   ok;
        ms++;
        a.edge_no = edge_no;
        a.rst     = bus_if.rst_n_out;
        a.done    = bus_if.done;
        a.glitch  = bus_if.glitch_err;
        a.rel     = bus_if.rel_cnt;
        if (vals(a) != vals(last_act) || (exp_q.size() != 0 && exp_q[0].edge_no <= edge_no)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_change edge=%0d got rst=%b done=%b glitch=%b rel=%0d",
                         edge_no, a.rst, a.done, a.glitch, a.rel);
            end else begin
                e = exp_q.pop_front();
                if (e.edge_no != edge_no || vals(e) != vals(a)) begin
                    bad++;
                    $display({"FAIL out_change got edge=%0d rst=%b done=%b glitch=%b rel=%0d",
                              " required edge=%0d rst=%b done=%b glitch=%b rel=%0d"},
                             edge_no, a.rst, a.done, a.glitch, a.rel,
                             e.edge_no, e.rst, e.done, e.glitch, e.rel);
                end
            end
        end
        for (int k = 0; k < NUM_RST; k++) begin
            if (a.rst[k] && !last_act.rst[k]) begin
                total++;
                ok = (k == 0) ? (ms - low_start >= MIN_ASSERT) : (ms - rise_ms[k-1] >= STAGGER);
                if (!ok) begin
                    bad++;
                    $display("FAIL release_spacing bit=%0d got gap=%0d required>=%0d", k,
                             (k == 0) ? ms - low_start : ms - rise_ms[k-1],
                             (k == 0) ? MIN_ASSERT : STAGGER);
                end
                rise_ms[k] = ms;
            end
        end
        if (a.rst == '0 && last_act.rst != '0) low_start = ms;
        last_act = a;
    end

    task automatic reset_pulse();
        rst_async = 1'b0;
        #1;
        chk("async_rst_n_out", int'(bus_if.rst_n_out), 0);
        chk("async_done", int'(bus_if.done), 0);
        chk("async_glitch_err", int'(bus_if.glitch_err), 0);
        chk("async_rel_cnt", int'(bus_if.rel_cnt), 0);
        model_reset();
        #1;
        rst_async = 1'b1;
    endtask

    initial begin
        logic v;
        int   n;
        rst_async        = 1'b0;
        bus_if.rst_req_n = 1'b1;
        for (int k = 0; k < NUM_RST; k++) rise_ms[k] = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_rst_n_out", int'(bus_if.rst_n_out), 0);
        chk("reset_done", int'(bus_if.done), 0);
        chk("reset_glitch_err", int'(bus_if.glitch_err), 0);
        chk("reset_rel_cnt", int'(bus_if.rel_cnt), 0);
        model_reset();
        #2;
        rst_async = 1'b1;

        hold(1'b1, 35);                       // power-up sequence
        hold(1'b0, 1);  hold(1'b1, 40);       // one-cycle glitch in RUN
        hold(1'b0, 4);  hold(1'b1, 40);       // full-length request in RUN
        chk("pre_pulse_glitch_err", int'(bus_if.glitch_err), 1);
        chk("pre_pulse_rel_cnt", int'(bus_if.rel_cnt), 3);
        reset_pulse();                        // mid-RUN async reset
        hold(1'b1, 35);
        hold(1'b0, 5);  hold(1'b1, 14);       // abort in SEQ after bit 1
        hold(1'b0, 2);  hold(1'b1, 40);

        // Enough complete sequences to saturate the release counter
        for (int i = 0; i < 260; i++) begin
            hold(1'b0, int'($urandom_range(1, 6)));
            hold(1'b1, 34);
        end
        chk("rel_cnt_saturated", int'(bus_if.rel_cnt), 255);

        v = 1'b1;
        n = edge_no;
        while (edge_no - n < 10000) begin
            v = ~v;
            hold(v, int'($urandom_range(1, 20)));
        end

        hold(1'b1, 40);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
